image_pixel_scanner: RTL and testbench

// - Raster-scans a parallel binary image of IMG_W x IMG_H pixels and streams one pixel per beat: value plus (x,y).
// - Generalises the fixed 8x8 scanner: parametrised size, start/done control, valid/ready output, repeatable frames.
// - Sits between the image source register and downstream pixel consumers (feature extract, coordinate logging).

---
 rtl/image_scan_pkg.sv | 15 +
 rtl/raster_coord_counter.sv | 57 +++++
 rtl/image_pixel_scanner.sv | 158 +++++++++++++++
 tb/tb_image_pixel_scanner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_scan_pkg.sv
// rtl/image_scan_pkg.sv - shared types and default geometry for the raster pixel scanner
// Purpose : scan FSM state encoding and default image size used by image_pixel_scanner.
// Contents: DEFAULT_IMG_W, DEFAULT_IMG_H, scan_state_e {IDLE, SCAN, DONE}.
package image_scan_pkg;

    localparam int DEFAULT_IMG_W = 8;
    localparam int DEFAULT_IMG_H = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/raster_coord_counter.sv
// rtl/raster_coord_counter.sv - x/y raster coordinate counter with clear, enable and wrap
// Purpose : tracks the (x,y) position of the current raster index; x wraps IMG_W-1 -> 0 and
//           bumps y, y wraps IMG_H-1 -> 0.
// Ports   : clk, rst_n (async active-low), clr (sync clear, wins over en), en (advance one pixel),
//           x [XW], y [YW], last (position is the final pixel of the frame).
module raster_coord_counter #(
    parameter int  IMG_W = 8,
    parameter int  IMG_H = 8,
    localparam int XW    = $clog2(IMG_W),
    localparam int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/image_pixel_scanner.sv
// rtl/image_pixel_scanner.sv - raster scanner streaming a latched binary image one pixel per beat
// Purpose : on start (IDLE only) latches img into a shadow register and streams its pixels in
//           row-major order with (x,y) over a valid/ready interface, then pulses done and
//           publishes the number of set pixels in the frame.
// Ports   : clk, rst_n (async active-low), start, img [NPIX],
//           out_valid, out_ready, out_pix, out_x [XW], out_y [YW], out_last,
//           busy (SCAN or DONE), done (one-cycle frame-end pulse), set_count [CW].
// Config  : IMG_SCAN_SKIP_ZERO_EN - when defined, zero pixels are skipped internally at one per
//           cycle and only set pixels are emitted; out_last marks the final set pixel.
module image_pixel_scanner
    import image_scan_pkg::*;
#(
    parameter int  IMG_W = DEFAULT_IMG_W,
    parameter int  IMG_H = DEFAULT_IMG_H,
    localparam int XW    = $clog2(IMG_W),
    localparam int YW    = $clog2(IMG_H),
    localparam int NPIX  = IMG_W * IMG_H,
    localparam int CW    = $clog2(NPIX + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NPIX-1:0] img,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_pix,
    output logic [XW-1:0]   out_x,
    output logic [YW-1:0]   out_y,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   set_count
);

    localparam int IW = $clog2(NPIX);

    scan_state_e     state_q, state_d;
    logic [NPIX-1:0] shadow_q, shadow_d;
    logic [IW-1:0]   index_q, index_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   set_count_q, set_count_d;

    logic            cnt_clr, cnt_en;
    logic [XW-1:0]   coord_x;
    logic [YW-1:0]   coord_y;
    logic            coord_last;

    logic            cur_pix;
    logic            beat_valid;
    logic            beat_last;
    logic            handshake;
    logic            advance;
    logic            finish;

    raster_coord_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_coord (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .x     (coord_x),
        .y     (coord_y),
        .last  (coord_last)
    );

    assign cur_pix = shadow_q[index_q];

`ifdef IMG_SCAN_SKIP_ZERO_EN
    logic [CW-1:0] index_p1;
    assign index_p1 = CW'(index_q) + 1'b1;

    // Only set pixels become beats; zeros are stepped over one per cycle without a beat.
    assign beat_valid = (state_q == SCAN) && cur_pix;
    // Last beat when nothing set remains strictly above the current index.
    assign beat_last  = ((shadow_q >> index_p1) == '0);
    assign handshake  = beat_valid && out_ready;
    assign advance    = handshake || ((state_q == SCAN) && !cur_pix);
    // A zero at the final index ends the frame with no pending beat.
    assign finish     = (handshake && beat_last) || ((state_q == SCAN) && !cur_pix && coord_last);
`else
    assign beat_valid = (state_q == SCAN);
    assign beat_last  = coord_last;
    assign handshake  = beat_valid && out_ready;
    assign advance    = handshake;
    assign finish     = handshake && beat_last;
`endif

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        index_d     = index_q;
        count_d     = count_q;
        set_count_d = set_count_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    shadow_d = img;
                    index_d  = '0;
                    count_d  = '0;
                    cnt_clr  = 1'b1;
                end
            end
            SCAN: begin
                if (handshake && cur_pix) begin
                    count_d = count_q + 1'b1;
                end
                if (finish) begin
                    state_d     = DONE;
                    // Publish including the final beat so set_count is valid alongside done.
                    set_count_d = count_d;
                end else if (advance) begin
                    index_d = index_q + 1'b1;
                    cnt_en  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                index_d = '0;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            index_q     <= '0;
            count_q     <= '0;
            set_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            index_q     <= index_d;
            count_q     <= count_d;
            set_count_q <= set_count_d;
        end
    end

    assign out_valid = beat_valid;
    assign out_pix   = (state_q == SCAN) && cur_pix;
    assign out_x     = coord_x;
    assign out_y     = coord_y;
    assign out_last  = beat_valid && beat_last;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign set_count = set_count_q;

endmodule

// File: tb/tb_image_pixel_scanner.sv
// tb/tb_image_pixel_scanner.sv - self-checking bench for image_pixel_scanner
module tb_image_pixel_scanner;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int XW   = 3;
    localparam int YW   = 3;
    localparam int CW   = 7;

    typedef logic [XW+YW+1:0] beat_t;   // {pix, x, y, last}

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [NPIX-1:0] img;
    logic            out_valid;
    logic            out_ready;
    logic            out_pix;
    logic [XW-1:0]   out_x;
    logic [YW-1:0]   out_y;
    logic            out_last;
    logic            busy;
    logic            done;
    logic [CW-1:0]   set_count;

    image_pixel_scanner #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .img       (img),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .set_count (set_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;

    beat_t exp_q[$];
    int    exp_count   = 0;
    int    exp_beats   = 0;
    bit    active      = 0;
    bit    done_due    = 0;
    bit    empty_frame = 0;
    bit    prev_stall  = 0;
    beat_t prev_beat   = '0;
    int    beats_acc   = 0;
    beat_t first_beat  = '0;
    beat_t last_beat   = '0;
    int    stall_cnt   = 0;
    bit    rand_ready  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat list straight from the image: row-major order, x=i%W, y=i/W.
    task automatic build_model(input logic [NPIX-1:0] im);
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
`ifdef IMG_SCAN_SKIP_ZERO_EN
            if (im[i]) begin
                exp_q.push_back({1'b1, XW'(i % W), YW'(i / W), ((im >> (i + 1)) == '0)});
            end
`else
            exp_q.push_back({im[i], XW'(i % W), YW'(i / W), (i == NPIX - 1)});
`endif
        end
        exp_count   = $countones(im);
        exp_beats   = exp_q.size();
        empty_frame = (exp_q.size() == 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic  de;
        beat_t cur;
        if (rst_n) begin
            de       = done_due;
            done_due = 0;
            cur      = {out_pix, out_x, out_y, out_last};
            if (prev_stall) check("hold", {out_valid, cur}, {1'b1, prev_beat});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {out_pix, out_x, out_y}, '1);
                end else begin
                    check("beat", cur, exp_q[0]);
                    if (out_ready) begin
                        if (beats_acc == 0) first_beat = cur;
                        last_beat = cur;
                        beats_acc++;
                        if (exp_q[0][0]) done_due = 1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = cur;
            check("busy", busy, active);
            if (empty_frame && active) begin
                if (done) begin
                    check("empty_set_count", set_count, 0);
                    active      = 0;
                    empty_frame = 0;
                end
            end else begin
                check("done", done, de);
                if (de) begin
                    check("set_count", set_count, exp_count);
                    active = 0;
                end
            end
        end
    end

    task automatic start_frame(input logic [NPIX-1:0] im);
        @(posedge clk); #1;
        img   = im;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        build_model(im);
        beats_acc = 0;
        active    = 1;
    endtask

    task automatic wait_frame_end();
        int n = 0;
        while (active && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check("frame_end", active, 0);
        if (active) begin
            active      = 0;
            empty_frame = 0;
            exp_q.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (beats_acc < n && c < 1000) begin
            @(negedge clk); #1;
            c++;
        end
        check("reach_beats", (beats_acc >= n), 1);
    endtask

    task automatic check_zero(input string name);
        check(name, {out_valid, out_pix, out_x, out_y, out_last, busy, done, set_count}, '0);
    endtask

    initial begin
        logic [NPIX-1:0] a;
        logic [NPIX-1:0] r;
        int              n;
        rst_n = 1'b0;
        start = 1'b0;
        img   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        #2 rst_n = 1'b1;

`ifndef IMG_SCAN_SKIP_ZERO_EN
        start_frame(64'h1);
        wait_frame_end();
        check("t1_beats", beats_acc, 64);
        check("t1_first", first_beat, {1'b1, 3'd0, 3'd0, 1'b0});
        check("t1_last", last_beat, {1'b0, 3'd7, 3'd7, 1'b1});
        check("t1_set_count", set_count, 1);

        start_frame(64'h8000_0000_0000_0000);
        wait_frame_end();
        check("t2_beats", beats_acc, 64);
        check("t2_first", first_beat, {1'b0, 3'd0, 3'd0, 1'b0});
        check("t2_last", last_beat, {1'b1, 3'd7, 3'd7, 1'b1});
        check("t2_set_count", set_count, 1);
`else
        start_frame(64'h8000_0000_0000_0001);
        wait_frame_end();
        check("s1_beats", beats_acc, 2);
        check("s1_first", first_beat, {1'b1, 3'd0, 3'd0, 1'b0});
        check("s1_last", last_beat, {1'b1, 3'd7, 3'd7, 1'b1});
        check("s1_set_count", set_count, 2);

        start_frame(64'h0);
        wait_frame_end();
        check("s2_beats", beats_acc, 0);
        check("s2_set_count", set_count, 0);
`endif

        // Backpressure on beat 5 (all-ones image gives 64 beats in either mode).
        start_frame('1);
        n = 0;
        while (!(out_valid && out_x == 3'd4 && out_y == 3'd0) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        stall_cnt = 3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("stall", {out_valid, out_ready, out_x, out_y}, {1'b1, 1'b0, 3'd5, 3'd0});
        end
        wait_frame_end();
        check("bp_beats", beats_acc, 64);
        check("bp_set_count", set_count, 64);

        // Image change plus start pulse mid-frame must not disturb the frame.
        rand_ready = 1;
        a = {$urandom, $urandom};
        a[0]  = 1'b1;
        a[63] = 1'b1;
        start_frame(a);
        wait_beats(3);
        img   = ~a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_frame_end();
        check("relatch_beats", beats_acc, exp_beats);
        check("relatch_set_count", set_count, $countones(a));

        for (int k = 0; k < 6; k++) begin
            r = {$urandom, $urandom};
            if (k == 1) r = r & {$urandom, $urandom} & {$urandom, $urandom};
            if (k == 2) r = r | {$urandom, $urandom};
            start_frame(r);
            wait_frame_end();
            check("rand_beats", beats_acc, exp_beats);
        end

        // Reset during a frame.
        rand_ready = 0;
        start_frame('1);
        wait_beats(20);
        rst_n = 1'b0;
        active      = 0;
        done_due    = 0;
        prev_stall  = 0;
        empty_frame = 0;
        exp_q.delete();
        @(negedge clk); #1;
        check_zero("reset_mid");
        @(negedge clk); #1;
        check("reset_no_done", {done, busy}, 2'b00);
        rst_n = 1'b1;
        r = {$urandom, $urandom};
        r[0] = 1'b1;
        start_frame(r);
        wait_frame_end();
        check("fresh_first_xy", first_beat[XW+YW:1], '0);
        check("fresh_beats", beats_acc, exp_beats);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
